// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing defaults for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

    localparam int RF_DSIZE = 16;
    localparam int RF_ASIZE = 4;
    localparam int RF_NREG  = 1 << RF_ASIZE;

    localparam int RF_WPORTS = 2;
    localparam int RF_RPORTS = 2;

endpackage

// File: rtl/regfile_busy.sv
// Busy (scoreboard) vector: per-register outstanding-write flags with issue set,
// writeback clear and flush.
module regfile_busy
    import regfile_scoreboard_pkg::*;
#(
    parameter int ASIZE    = RF_ASIZE,
    parameter int NREG     = RF_NREG,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             set_en,
    input  logic [ASIZE-1:0]                 set_addr,
    input  logic [RF_WPORTS-1:0]             clr_en,
    input  logic [RF_WPORTS-1:0][ASIZE-1:0]  clr_addr,
    input  logic                             flush,
    output logic [NREG-1:0]                  busy_vec
);

    logic [NREG-1:0] busy_nxt;

    // Order matters: flush, then writeback clears, then issue set, so a new
    // producer issued in the same cycle always ends up marked busy.
    always_comb begin
        busy_nxt = flush ? '0 : busy_vec;
        for (int k = 0; k < RF_WPORTS; k++) begin
            if (clr_en[k]) busy_nxt[clr_addr[k]] = 1'b0;
        end
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write / two-read flop register file with writeback bypass and a busy
// scoreboard; port 1 (ALU writeback) has priority over port 0.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DSIZE    = RF_DSIZE,
    parameter int ASIZE    = RF_ASIZE,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen0,
    input  logic [ASIZE-1:0]       waddr0,
    input  logic [DSIZE-1:0]       wdata0,
    input  logic                   wen1,
    input  logic [ASIZE-1:0]       waddr1,
    input  logic [DSIZE-1:0]       wdata1,
    input  logic [ASIZE-1:0]       raddr1,
    input  logic [ASIZE-1:0]       raddr2,
    output logic [DSIZE-1:0]       rdata1,
    output logic [DSIZE-1:0]       rdata2,
    output logic                   rbusy1,
    output logic                   rbusy2,
    input  logic                   iss_en,
    input  logic [ASIZE-1:0]       iss_addr,
    input  logic                   flush,
    output logic [(1<<ASIZE)-1:0]  busy_vec
);

    localparam int NREG = 1 << ASIZE;

    logic [RF_WPORTS-1:0]            wen;
    logic [RF_WPORTS-1:0][ASIZE-1:0] waddr;
    logic [RF_WPORTS-1:0][DSIZE-1:0] wdata;
    logic [RF_RPORTS-1:0][ASIZE-1:0] raddr;
    logic [RF_RPORTS-1:0][DSIZE-1:0] rdata_v;
    logic [RF_RPORTS-1:0]            rbusy_v;
    logic [DSIZE-1:0]                regs [NREG];

    assign wen   = {wen1, wen0};
    assign waddr = {waddr1, waddr0};
    assign wdata = {wdata1, wdata0};
    assign raddr = {raddr2, raddr1};

    assign rdata1 = rdata_v[0];
    assign rdata2 = rdata_v[1];
    assign rbusy1 = rbusy_v[0];
    assign rbusy2 = rbusy_v[1];

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (ZERO_REG && g == 0) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_flop
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    regs[g] <= '0;
                else if (wen[1] && waddr[1] == ASIZE'(g))
                    regs[g] <= wdata[1];
                else if (wen[0] && waddr[0] == ASIZE'(g))
                    regs[g] <= wdata[0];
            end
        end
    end

    for (genvar p = 0; p < RF_RPORTS; p++) begin : g_rd
        logic [DSIZE-1:0] rd;
        logic             hit0, hit1, zero_rd;

        assign hit0    = wen[0] && (waddr[0] == raddr[p]);
        assign hit1    = wen[1] && (waddr[1] == raddr[p]);
        assign zero_rd = ZERO_REG && (raddr[p] == '0);

        always_comb begin
            rd = regs[raddr[p]];
            if (hit0) rd = wdata[0];
            if (hit1) rd = wdata[1];
            if (zero_rd) rd = '0;
        end

        // A writeback landing this cycle is forwarded, so the operand is ready.
        assign rdata_v[p] = rd;
        assign rbusy_v[p] = busy_vec[raddr[p]] && !hit0 && !hit1 && !zero_rd;
    end

    regfile_busy #(
        .ASIZE    (ASIZE),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_en),
        .set_addr (iss_addr),
        .clr_en   (wen),
        .clr_addr (waddr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard, two instances
// (ZERO_REG=0 and ZERO_REG=1) sharing one stimulus stream.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen0, wen1, iss_en, flush;
    logic [3:0]  waddr0, waddr1, raddr1, raddr2, iss_addr;
    logic [15:0] wdata0, wdata1;

    logic [15:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        rbusy1_a, rbusy2_a, rbusy1_b, rbusy2_b;
    logic [15:0] busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: index 0 -> ZERO_REG=0 instance, index 1 -> ZERO_REG=1.
    logic [15:0] m_mem  [2][16];
    bit          m_busy [2][16];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DSIZE(16), .ASIZE(4), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a),
        .rbusy1(rbusy1_a), .rbusy2(rbusy2_a),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_vec(busy_a)
    );

    regfile_scoreboard #(.DSIZE(16), .ASIZE(4), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b),
        .rbusy1(rbusy1_b), .rbusy2(rbusy2_b),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_vec(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int z, input logic [3:0] ra);
        if (z == 1 && ra == 0) return 16'h0;
        if (wen1 && waddr1 == ra) return wdata1;
        if (wen0 && waddr0 == ra) return wdata0;
        return m_mem[z][ra];
    endfunction

    function automatic logic exp_rb(input int z, input logic [3:0] ra);
        if (z == 1 && ra == 0) return 1'b0;
        if ((wen1 && waddr1 == ra) || (wen0 && waddr0 == ra)) return 1'b0;
        return m_busy[z][ra];
    endfunction

    function automatic logic [15:0] exp_vec(input int z);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[z][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 16; i++) begin
                m_mem[z][i]  = 16'h0;
                m_busy[z][i] = 1'b0;
            end
    endtask

    // Applies one clock edge's worth of architectural effect to the model.
    task automatic model_update();
        if (rst) begin
            model_reset();
            return;
        end
        for (int z = 0; z < 2; z++) begin
            if (wen0 && !(z == 1 && waddr0 == 0)) m_mem[z][waddr0] = wdata0;
            if (wen1 && !(z == 1 && waddr1 == 0)) m_mem[z][waddr1] = wdata1;
            if (flush)
                for (int i = 0; i < 16; i++) m_busy[z][i] = 1'b0;
            if (wen0) m_busy[z][waddr0] = 1'b0;
            if (wen1) m_busy[z][waddr1] = 1'b0;
            if (iss_en && !(z == 1 && iss_addr == 0)) m_busy[z][iss_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("rdata1_a", rdata1_a, exp_rd(0, raddr1));
        chk("rdata2_a", rdata2_a, exp_rd(0, raddr2));
        chk("rbusy1_a", rbusy1_a, exp_rb(0, raddr1));
        chk("rbusy2_a", rbusy2_a, exp_rb(0, raddr2));
        chk("busy_a",   busy_a,   exp_vec(0));
        chk("rdata1_b", rdata1_b, exp_rd(1, raddr1));
        chk("rdata2_b", rdata2_b, exp_rd(1, raddr2));
        chk("rbusy1_b", rbusy1_b, exp_rb(1, raddr1));
        chk("rbusy2_b", rbusy2_b, exp_rb(1, raddr2));
        chk("busy_b",   busy_b,   exp_vec(1));
    endtask

    task automatic drv(input logic r, input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                       input logic w1, input logic [3:0] a1, input logic [15:0] d1,
                       input logic [3:0] r1, input logic [3:0] r2,
                       input logic ie, input logic [3:0] ia, input logic fl);
        rst = r; wen0 = w0; waddr0 = a0; wdata0 = d0;
        wen1 = w1; waddr1 = a1; wdata1 = d1;
        raddr1 = r1; raddr2 = r2; iss_en = ie; iss_addr = ia; flush = fl;
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled 4 later.
    task automatic cycle();
        if (rst) model_reset();
        #4;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        model_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state across all addresses
        for (int i = 0; i < 16; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(15 - i), 0, 0, 0);
            #4;
            chk("rst_rd", rdata1_a, 16'h0);
            chk("rst_vec", busy_a, 16'h0);
            #1;
            cycle();
        end

        // Bypass of port 0 then stored value
        drv(0, 1, 3, 16'h1234, 0, 0, 0, 3, 3, 0, 0, 0);
        #4; chk("byp0", rdata1_a, 16'h1234); #1;
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        #4; chk("stored3", rdata1_a, 16'h1234); #1;
        cycle();

        // Dual write to one address: port 1 wins
        drv(0, 1, 5, 16'h1111, 1, 5, 16'h2222, 5, 5, 0, 0, 0);
        #4; chk("dual_byp", rdata2_a, 16'h2222); #1;
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0);
        #4; chk("dual_st", rdata1_a, 16'h2222); #1;
        cycle();

        // Issue, busy, writeback clears
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0);
        #4; chk("busy7", rbusy1_a, 1'b1); #1;
        cycle();
        drv(0, 1, 7, 16'h00AA, 0, 0, 0, 7, 7, 0, 0, 0);
        #4; chk("wb7_rb", rbusy1_a, 1'b0); chk("wb7_rd", rdata1_a, 16'h00AA); #1;
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0);
        #4; chk("vec7", busy_a[7], 1'b0); #1;
        cycle();

        // Issue + write same address: busy stays set
        drv(0, 1, 8, 16'h0808, 0, 0, 0, 8, 8, 1, 8, 0);
        cycle();

        // Flush with simultaneous issue
        drv(0, 0, 0, 0, 0, 0, 0, 2, 4, 1, 2, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 2, 4, 1, 4, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 2, 4, 1, 9, 1);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 9, 2, 0, 0, 0);
        #4; chk("flush_vec", busy_a, 16'h0200); #1;
        cycle();

        // Hard-wired zero register
        drv(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 1, 0, 0);
        #4; chk("z_rd", rdata1_b, 16'h0); chk("z_rb", rbusy1_b, 1'b0); #1;
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        #4; chk("z_vec0", busy_b[0], 1'b0); #1;
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 3, 6, 1, 6, 0);
        cycle();

        // Asynchronous reset mid-cycle with busy bits outstanding
        drv(0, 1, 11, 16'hBEEF, 0, 0, 0, 3, 6, 1, 12, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_a", busy_a, 16'h0);
        chk("arst_b", busy_b, 16'h0);
        #1;
        check_all();
        @(posedge clk);
        model_update();
        #1;
        drv(0, 0, 0, 0, 0, 0, 0, 11, 12, 0, 0, 0);
        #4; chk("arst_nowr", rdata1_a, 16'h0); #1;
        cycle();

        // Random stream
        for (int n = 0; n < 600; n++) begin
            drv(($urandom % 64) == 0,
                $urandom % 2, 4'($urandom), 16'($urandom),
                $urandom % 2, 4'($urandom), 16'($urandom),
                4'($urandom), 4'($urandom),
                $urandom % 2, 4'($urandom), ($urandom % 16) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
